// File: rtl/fetch_branch_unit_if.sv
// Instruction-memory and execute-stage handshake bundle for fetch_branch_unit.
//   mem_req/mem_addr   : read request and address toward instruction memory
//   mem_ack/mem_rdata  : read completion, data valid in the ack cycle
//   instr_valid/instr_out/exec_ready : valid/ready issue channel toward execute
// master = fetch unit side, slave = memory/execute side.
interface fetch_branch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic               exec_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_out,
    input  mem_ack, mem_rdata, exec_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out,
    output mem_ack, mem_rdata, exec_ready
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// Fetch and branch-resolution unit. Fetches from instruction memory at the current PC, resolves
// JMP/BZ/BNZ/CALL/RET/HALT locally and issues every other instruction to execute.
// The PC has no hold input, so "hold" means reloading pc_in.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   pc_in          : current PC value
//   pc_load_en     : PC load enable (0 lets the PC increment)
//   pc_next_addr   : value loaded when pc_load_en=1
//   zero_flag      : ALU zero flag, sampled in DECODE
//   bus            : memory req/ack and execute valid/ready channel (master side)
//   halted         : unit is in HALTED
//   stack_err      : sticky return-address stack overflow/underflow
module fetch_branch_unit #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic                pc_load_en,
  output logic [ADDR_W-1:0]   pc_next_addr,
  input  logic                zero_flag,
  fetch_branch_unit_if.master bus,
  output logic                halted,
  output logic                stack_err
);

  localparam int unsigned DW = $clog2(RAS_DEPTH + 1);
  localparam logic [DW-1:0] RasFull = DW'(RAS_DEPTH);

  localparam logic [3:0] OpJmp  = 4'h1;
  localparam logic [3:0] OpBz   = 4'h2;
  localparam logic [3:0] OpBnz  = 4'h3;
  localparam logic [3:0] OpCall = 4'h4;
  localparam logic [3:0] OpRet  = 4'h5;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [1:0] {StFetch, StDecode, StIssue, StHalted} state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic               stack_err_q, stack_err_d;
  logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];

  logic               push;
  logic [ADDR_W-1:0]  ret_addr;
  logic [ADDR_W-1:0]  pop_addr;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  target;

  assign opcode    = ir_q[INSTR_W-1 -: 4];
  assign target    = ir_q[ADDR_W-1:0];
  assign ret_addr  = pc_in + ADDR_W'(1);
  assign stack_err = stack_err_q;

  // Top-of-stack entry lives at index depth-1.
  always_comb begin
    pop_addr = '0;
    for (int i = 0; i < int'(RAS_DEPTH); i++) begin
      if (depth_q == DW'(i + 1)) pop_addr = ras_q[i];
    end
  end

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    depth_d         = depth_q;
    stack_err_d     = stack_err_q;
    push            = 1'b0;
    pc_load_en      = 1'b1;
    pc_next_addr    = pc_in;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = pc_in;
    bus.instr_valid = 1'b0;
    bus.instr_out   = ir_q;
    halted          = 1'b0;

    unique case (state_q)
      StFetch: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StFetch;
        case (opcode)
          OpJmp: pc_next_addr = target;
          OpBz: begin
            if (zero_flag) pc_next_addr = target;
            else           pc_load_en   = 1'b0;
          end
          OpBnz: begin
            if (!zero_flag) pc_next_addr = target;
            else            pc_load_en   = 1'b0;
          end
          OpCall: begin
            if (depth_q < RasFull) begin
              push         = 1'b1;
              depth_d      = depth_q + DW'(1);
              pc_next_addr = target;
            end else begin
              stack_err_d = 1'b1;
              state_d     = StHalted;
            end
          end
          OpRet: begin
            if (depth_q != '0) begin
              depth_d      = depth_q - DW'(1);
              pc_next_addr = pop_addr;
            end else begin
              stack_err_d = 1'b1;
              state_d     = StHalted;
            end
          end
          OpHalt:  state_d = StHalted;
          default: state_d = StIssue;
        endcase
      end
      StIssue: begin
        bus.instr_valid = 1'b1;
        if (bus.exec_ready) begin
          pc_load_en = 1'b0;
          state_d    = StFetch;
        end
      end
      StHalted: halted = 1'b1;
      default:  state_d = StFetch;
    endcase

    // Reset forces the PC to zero and silences both handshakes; state regs reset in always_ff.
    if (!reset_n) begin
      bus.mem_req     = 1'b0;
      bus.instr_valid = 1'b0;
      pc_load_en      = 1'b1;
      pc_next_addr    = '0;
      halted          = 1'b0;
      push            = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      ir_q        <= '0;
      depth_q     <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      depth_q     <= depth_d;
      stack_err_q <= stack_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RAS_DEPTH); i++) begin
      if (push && depth_q == DW'(i)) ras_q[i] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
module tb_fetch_branch_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pc;
  logic       pc_load_en;
  logic [7:0] pc_next_addr;
  logic       zero_flag = 1'b0;
  logic       halted;
  logic       stack_err;

  logic [15:0] mem [256];
  int          lat = 1;
  int          req_cnt = 0;
  logic        force_ack = 1'b0;
  logic        exec_ready = 1'b1;
  logic        pc_force = 1'b0;
  logic [7:0]  pc_force_val = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  int n_req, n_loadlow, n_valid, n_addr_bad;
  logic [15:0] issue_log [$];
  logic [7:0]  fetch_log [$];

  fetch_branch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  fetch_branch_unit #(.ADDR_W(8), .INSTR_W(16), .RAS_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_in        (pc),
    .pc_load_en   (pc_load_en),
    .pc_next_addr (pc_next_addr),
    .zero_flag    (zero_flag),
    .bus          (bus.master),
    .halted       (halted),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  // Program counter model: load or increment, with a bench-side preset.
  always @(posedge clk) begin
    if (pc_force)        pc <= pc_force_val;
    else if (pc_load_en) pc <= pc_next_addr;
    else                 pc <= pc + 8'd1;
  end

  // Memory answers after lat cycles of continuous request.
  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) req_cnt <= 0;
    else                             req_cnt <= req_cnt + 1;
  end
  assign bus.mem_ack    = force_ack | (bus.mem_req && (req_cnt == lat - 1));
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus.exec_ready = exec_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_req = 0; n_loadlow = 0; n_valid = 0; n_addr_bad = 0;
    issue_log.delete();
    fetch_log.delete();
  endtask

  // Sample outputs mid-cycle, then advance to the next falling edge.
  task automatic step();
    #1;
    if (bus.mem_req) n_req++;
    if (bus.mem_req && bus.mem_addr !== pc) n_addr_bad++;
    if (bus.mem_req && bus.mem_ack) fetch_log.push_back(bus.mem_addr);
    if (!pc_load_en) n_loadlow++;
    if (bus.instr_valid) n_valid++;
    if (bus.instr_valid && exec_ready) issue_log.push_back(bus.instr_out);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [7:0] start);
    reset_n = 1'b0;
    pc_force = 1'b1;
    pc_force_val = start;
    @(negedge clk);
    reset_n = 1'b1;
    pc_force = 1'b0;
    clear_mon();
  endtask

  typedef struct {
    logic [7:0]  start;
    logic [15:0] instr;
    logic        zf;
    logic [7:0]  exp_pc;
    logic        exp_halted;
    logic        exp_err;
    int          exp_issued;
  } vec_t;

  vec_t vecs [12];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    vecs[0]  = '{8'h05, 16'h2020, 1'b0, 8'h06, 1'b0, 1'b0, 0};  // BZ not taken
    vecs[1]  = '{8'h05, 16'h2020, 1'b1, 8'h20, 1'b0, 1'b0, 0};  // BZ taken
    vecs[2]  = '{8'h05, 16'h3020, 1'b0, 8'h20, 1'b0, 1'b0, 0};  // BNZ taken
    vecs[3]  = '{8'h05, 16'h3020, 1'b1, 8'h06, 1'b0, 1'b0, 0};  // BNZ not taken
    vecs[4]  = '{8'h00, 16'h1040, 1'b0, 8'h40, 1'b0, 1'b0, 0};  // JMP
    vecs[5]  = '{8'h10, 16'h4080, 1'b0, 8'h80, 1'b0, 1'b0, 0};  // CALL
    vecs[6]  = '{8'h33, 16'h5000, 1'b0, 8'h33, 1'b1, 1'b1, 0};  // RET on empty stack
    vecs[7]  = '{8'h07, 16'hF000, 1'b0, 8'h07, 1'b1, 1'b0, 0};  // HALT
    vecs[8]  = '{8'h12, 16'h6011, 1'b0, 8'h13, 1'b0, 1'b0, 1};  // ALU op issued
    vecs[9]  = '{8'hFF, 16'h0ABC, 1'b0, 8'h00, 1'b0, 1'b0, 1};  // opcode 0, PC wraps
    vecs[10] = '{8'h20, 16'hE123, 1'b0, 8'h21, 1'b0, 1'b0, 1};  // opcode E issued
    vecs[11] = '{8'hFF, 16'h1000, 1'b0, 8'h00, 1'b0, 1'b0, 0};  // JMP to 0 from 0xFF

    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_load_en", 32'(pc_load_en), 32'd1);
    chk("rst_next_addr", 32'(pc_next_addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_stack_err", 32'(stack_err), 32'd0);
    @(negedge clk);

    // Single-instruction decode table, 1-cycle memory.
    foreach (vecs[k]) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[vecs[k].start] = vecs[k].instr;
      zero_flag = vecs[k].zf;
      exec_ready = 1'b1;
      lat = 1;
      do_reset(vecs[k].start);
      steps(3);
      chk($sformatf("v%0d_pc", k), 32'(pc), 32'(vecs[k].exp_pc));
      chk($sformatf("v%0d_halted", k), 32'(halted), 32'(vecs[k].exp_halted));
      chk($sformatf("v%0d_err", k), 32'(stack_err), 32'(vecs[k].exp_err));
      chk($sformatf("v%0d_issued", k), 32'(issue_log.size()), 32'(vecs[k].exp_issued));
      if (vecs[k].exp_issued == 1 && issue_log.size() == 1)
        chk($sformatf("v%0d_instr", k), 32'(issue_log[0]), 32'(vecs[k].instr));
    end
    zero_flag = 1'b0;

    // Two straight-line instructions.
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h6011; mem[1] = 16'h7022;
    do_reset(8'h00);
    steps(6);
    chk("seq_fetch_cnt", 32'(fetch_log.size()), 32'd2);
    if (fetch_log.size() == 2) begin
      chk("seq_addr0", 32'(fetch_log[0]), 32'h00);
      chk("seq_addr1", 32'(fetch_log[1]), 32'h01);
    end
    chk("seq_issue_cnt", 32'(issue_log.size()), 32'd2);
    if (issue_log.size() == 2) begin
      chk("seq_instr0", 32'(issue_log[0]), 32'h6011);
      chk("seq_instr1", 32'(issue_log[1]), 32'h7022);
    end
    chk("seq_loadlow", 32'(n_loadlow), 32'd2);
    chk("seq_pc", 32'(pc), 32'h02);

    // JMP with 3-cycle memory latency.
    mem[0] = 16'h1040;
    lat = 3;
    do_reset(8'h00);
    steps(3);
    chk("jmp_req_cycles", 32'(n_req), 32'd3);
    chk("jmp_addr_bad", 32'(n_addr_bad), 32'd0);
    chk("jmp_pc_held", 32'(pc), 32'h00);
    #1;
    chk("jmp_load_en", 32'(pc_load_en), 32'd1);
    chk("jmp_next_addr", 32'(pc_next_addr), 32'h40);
    step();
    chk("jmp_pc", 32'(pc), 32'h40);
    chk("jmp_no_valid", 32'(n_valid), 32'd0);
    lat = 1;

    // CALL then RET.
    mem[8'h10] = 16'h4080; mem[8'h80] = 16'h5000;
    do_reset(8'h10);
    steps(2);
    chk("call_pc", 32'(pc), 32'h80);
    steps(2);
    chk("ret_pc", 32'(pc), 32'h11);
    chk("callret_valid", 32'(n_valid), 32'd0);

    // CALL at 0xFF returns to 0x00.
    mem[8'hFF] = 16'h4080;
    do_reset(8'hFF);
    steps(4);
    chk("wrap_ret_pc", 32'(pc), 32'h00);
    chk("wrap_err", 32'(stack_err), 32'd0);

    // Five nested CALLs overflow a 4-deep stack.
    mem[8'h00] = 16'h4010; mem[8'h10] = 16'h4020; mem[8'h20] = 16'h4030;
    mem[8'h30] = 16'h4040; mem[8'h40] = 16'h4050;
    do_reset(8'h00);
    steps(8);
    chk("nest_pc4", 32'(pc), 32'h40);
    chk("nest_err_early", 32'(stack_err), 32'd0);
    steps(4);
    chk("nest_err", 32'(stack_err), 32'd1);
    chk("nest_halted", 32'(halted), 32'd1);
    chk("nest_pc_held", 32'(pc), 32'h40);

    // Execute back-pressure.
    mem[0] = 16'h6ABC;
    exec_ready = 1'b0;
    do_reset(8'h00);
    steps(2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_valid%0d", i), 32'(bus.instr_valid), 32'd1);
      chk($sformatf("bp_instr%0d", i), 32'(bus.instr_out), 32'h6ABC);
      chk($sformatf("bp_pc%0d", i), 32'(pc), 32'h00);
      chk($sformatf("bp_load%0d", i), 32'(pc_load_en), 32'd1);
      @(negedge clk);
    end
    exec_ready = 1'b1;
    #1;
    chk("bp_release_load", 32'(pc_load_en), 32'd0);
    step();
    chk("bp_pc_inc", 32'(pc), 32'h01);
    #1;
    chk("bp_valid_drop", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);

    // Reset during a pending fetch; the late ack must be ignored.
    mem[0] = 16'h1040;
    lat = 3;
    do_reset(8'h00);
    step();
    reset_n = 1'b0;
    force_ack = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_load", 32'(pc_load_en), 32'd1);
    chk("midrst_next", 32'(pc_next_addr), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    force_ack = 1'b0;
    mem[0] = 16'h6055;
    lat = 1;
    clear_mon();
    steps(3);
    chk("midrst_refetch", 32'(fetch_log.size() > 0 ? fetch_log[0] : 8'hAA), 32'h00);
    chk("midrst_issue_cnt", 32'(issue_log.size()), 32'd1);
    if (issue_log.size() == 1) chk("midrst_instr", 32'(issue_log[0]), 32'h6055);
    chk("midrst_pc", 32'(pc), 32'h01);

    // HALT holds until reset.
    mem[0] = 16'hF000;
    do_reset(8'h00);
    steps(2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("halt_flag%0d", i), 32'(halted), 32'd1);
      chk($sformatf("halt_req%0d", i), 32'(bus.mem_req), 32'd0);
      chk($sformatf("halt_pc%0d", i), 32'(pc), 32'h00);
      @(negedge clk);
    end
    mem[0] = 16'h0000;
    do_reset(8'h00);
    #1;
    chk("halt_cleared", 32'(halted), 32'd0);
    chk("halt_refetch", 32'(bus.mem_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
